vga_frame_arbiter: RTL and testbench

//  Shares one single-port synchronous pixel RAM between VGA scan-out and a pixel writer (draw engine/CPU).

---
 rtl/vga_pkg.sv | 33 +++
 rtl/pixel_fifo.sv | 59 +++++
 rtl/vga_frame_arbiter.sv | 139 +++++++++++++
 tb/tb_vga_frame_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and defaults for the VGA frame-buffer arbiter and its helpers.
// Coordinates are fixed at 10 bits to match VGAController's posx/posy.
package vga_pkg;

    localparam int H_RES_DEF   = 640;
    localparam int V_RES_DEF   = 480;
    localparam int PIX_LATENCY = 3;
    localparam int COORD_W     = 10;
    localparam int PIX_W       = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } arb_state_t;

    // wr_req_t carries PIX_W pixel data, so DATA_W on the top must match PIX_W
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [PIX_W-1:0]   data;
    } wr_req_t;

    function automatic logic coord_in_range(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input int                 h_res,
        input int                 v_res
    );
        return (int'(x) < h_res) && (int'(y) < v_res);
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO with occupancy count; DEPTH must be a power of 2.
// Head entry is visible on pop_data whenever the FIFO is non-empty.
module pixel_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/vga_frame_arbiter.sv
// Shares one single-port pixel RAM between VGA scan-out and a buffered pixel writer.
// Scan-out owns the RAM during active video; buffered writes drain only in blanking.
//
//  state | meaning
//  IDLE  | blanking, nothing buffered; RAM untouched, address held
//  SCAN  | active video; RAM address follows the beam
//  DRAIN | blanking; one buffered pixel written to RAM this cycle
module vga_frame_arbiter
    import vga_pkg::*;
#(
    parameter  int H_RES      = H_RES_DEF,
    parameter  int V_RES      = V_RES_DEF,
    parameter  int ADDR_W     = 19,
    parameter  int DATA_W     = PIX_W,
    parameter  int FIFO_DEPTH = 4,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] posx,
    input  logic [COORD_W-1:0] posy,
    input  logic               blank_n_in,
    input  logic               h_sync_in,
    input  logic               v_sync_in,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               wr_drop,
    output logic [LVL_W-1:0]   fifo_level,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [DATA_W-1:0]  pix_data,
    output logic               h_sync_out,
    output logic               v_sync_out,
    output logic               blank_n_out
);

    arb_state_t             state;
    wr_req_t                req_in;
    wr_req_t                req_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   accept;
    logic                   in_range;
    logic                   ready_en;
    logic [PIX_LATENCY-1:0] blank_d;
    logic [PIX_LATENCY-1:0] hsync_d;
    logic [PIX_LATENCY-1:0] vsync_d;

    function automatic logic [ADDR_W-1:0] pix_addr(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y
    );
        return ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
    endfunction

    assign req_in.x    = wr_x;
    assign req_in.y    = wr_y;
    assign req_in.data = wr_data;

    assign in_range  = coord_in_range(wr_x, wr_y, H_RES, V_RES);
    assign wr_ready  = ready_en && !fifo_full;
    assign accept    = wr_valid && wr_ready;
    assign fifo_push = accept && in_range;
    assign fifo_pop  = !blank_n_in && !fifo_empty;

    pixel_fifo #(
        .WIDTH ($bits(wr_req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (fifo_push),
        .push_data (req_in),
        .pop       (fifo_pop),
        .pop_data  (req_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Out-of-range pixels still complete the handshake so the writer never stalls on them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en <= 1'b0;
            wr_drop  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            wr_drop  <= accept && !in_range;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (blank_n_in) begin
                state    <= SCAN;
                mem_addr <= pix_addr(posx, posy);
            end else if (!fifo_empty) begin
                state     <= DRAIN;
                mem_addr  <= pix_addr(req_head.x, req_head.y);
                mem_wdata <= req_head.data;
            end else begin
                state <= IDLE;
            end
        end
    end

    // Write enable is a direct decode of the state register, so it can never disagree with it
    assign mem_we = (state == DRAIN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blank_d  <= '0;
            hsync_d  <= '1;
            vsync_d  <= '1;
            pix_data <= '0;
        end else begin
            blank_d  <= {blank_d[PIX_LATENCY-2:0], blank_n_in};
            hsync_d  <= {hsync_d[PIX_LATENCY-2:0], h_sync_in};
            vsync_d  <= {vsync_d[PIX_LATENCY-2:0], v_sync_in};
            pix_data <= blank_d[PIX_LATENCY-2] ? mem_rdata : '0;
        end
    end

    assign blank_n_out = blank_d[PIX_LATENCY-1];
    assign h_sync_out  = hsync_d[PIX_LATENCY-1];
    assign v_sync_out  = vsync_d[PIX_LATENCY-1];

endmodule

// File: tb/tb_vga_frame_arbiter.sv
// Self-checking bench for vga_frame_arbiter with a behavioural RAM and a queue-based reference model.
// Random scan-out stays in rows 0..399 while random writes target rows 400+, so reads see preload values.
module tb_vga_frame_arbiter;
    import vga_pkg::*;

    localparam int H     = 640;
    localparam int V     = 480;
    localparam int AW    = 19;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic               clk;
    logic               rst;
    logic [COORD_W-1:0] posx;
    logic [COORD_W-1:0] posy;
    logic               blank_n_in;
    logic               h_sync_in;
    logic               v_sync_in;
    logic               wr_valid;
    logic               wr_ready;
    logic [COORD_W-1:0] wr_x;
    logic [COORD_W-1:0] wr_y;
    logic [DW-1:0]      wr_data;
    logic               wr_drop;
    logic [LW-1:0]      fifo_level;
    logic [AW-1:0]      mem_addr;
    logic               mem_we;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;
    logic [DW-1:0]      pix_data;
    logic               h_sync_out;
    logic               v_sync_out;
    logic               blank_n_out;

    vga_frame_arbiter #(
        .H_RES (H), .V_RES (V), .ADDR_W (AW), .DATA_W (DW), .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk), .rst (rst), .posx (posx), .posy (posy),
        .blank_n_in (blank_n_in), .h_sync_in (h_sync_in), .v_sync_in (v_sync_in),
        .wr_valid (wr_valid), .wr_ready (wr_ready), .wr_x (wr_x), .wr_y (wr_y),
        .wr_data (wr_data), .wr_drop (wr_drop), .fifo_level (fifo_level),
        .mem_addr (mem_addr), .mem_we (mem_we), .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata), .pix_data (pix_data), .h_sync_out (h_sync_out),
        .v_sync_out (v_sync_out), .blank_n_out (blank_n_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM; unwritten locations read back the low byte of their address
    bit [DW-1:0] ram     [1 << AW];
    bit          written [1 << AW];
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        mem_rdata <= written[mem_addr] ? ram[mem_addr] : mem_addr[DW-1:0];
    end

    typedef struct { logic blank; logic hs; logic vs; logic [AW-1:0] addr; } vid_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wreq_t;

    vid_t          hist[$];
    wreq_t         mq[$];
    logic [DW-1:0] ovr[int];
    bit            started;
    bit            exp_we;
    bit            exp_drop;
    bit            exp_ready;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    int            checks = 0;
    int            errors = 0;

    function automatic logic [AW-1:0] addr_of(input int x, input int y);
        return AW'(y * H + x);
    endfunction

    function automatic logic [DW-1:0] mem_exp(input logic [AW-1:0] a);
        if (ovr.exists(int'(a))) return ovr[int'(a)];
        return a[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] exp_pix();
        return hist[0].blank ? mem_exp(hist[0].addr) : '0;
    endfunction

    task automatic model_reset();
        vid_t r;
        r.blank = 1'b0; r.hs = 1'b1; r.vs = 1'b1; r.addr = '0;
        mq.delete();
        hist.delete();
        repeat (3) hist.push_back(r);
        started = 0; exp_we = 0; exp_drop = 0; exp_ready = 0;
        exp_addr = '0; exp_wdata = '0;
    endtask

    // One clock: the model consumes the inputs present at the edge, then we move to the falling edge
    task automatic tick();
        bit    rdy, acc, inr;
        wreq_t h;
        vid_t  v;
        @(posedge clk);
        rdy = started && (mq.size() < DEPTH);
        acc = wr_valid && rdy;
        inr = (int'(wr_x) < H) && (int'(wr_y) < V);
        if (!blank_n_in && mq.size() > 0) begin
            h = mq.pop_front();
            exp_we = 1; exp_addr = h.addr; exp_wdata = h.data;
            ovr[int'(h.addr)] = h.data;
        end else begin
            exp_we = 0;
            if (blank_n_in) exp_addr = addr_of(int'(posx), int'(posy));
        end
        if (acc && inr) begin
            h.addr = addr_of(int'(wr_x), int'(wr_y));
            h.data = wr_data;
            mq.push_back(h);
        end
        exp_drop = acc && !inr;
        v.blank = blank_n_in; v.hs = h_sync_in; v.vs = v_sync_in;
        v.addr  = addr_of(int'(posx), int'(posy));
        hist.push_back(v);
        hist.delete(0);
        started   = 1;
        exp_ready = (mq.size() < DEPTH);
        @(negedge clk);
    endtask

    task automatic drive_video(input bit b, input int x, input int y, input bit hs, input bit vs);
        blank_n_in = b; posx = 10'(x); posy = 10'(y); h_sync_in = hs; v_sync_in = vs;
    endtask

    task automatic drive_wr(input bit v, input int x, input int y, input int d);
        wr_valid = v; wr_x = 10'(x); wr_y = 10'(y); wr_data = 8'(d);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_video(0, 0, 0, 1, 1);
        drive_wr(0, 0, 0, 0);
        model_reset();
        @(negedge clk); @(negedge clk);
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got %0b want 0", wr_ready); end
        checks++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", mem_we); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr got %0d want 0", mem_addr); end
        checks++; if (pix_data !== '0) begin errors++; $display("FAIL reset_pix got %0h want 0", pix_data); end
        checks++; if (blank_n_out !== 1'b0) begin errors++; $display("FAIL reset_blank got %0b want 0", blank_n_out); end
        checks++; if (h_sync_out !== 1'b1 || v_sync_out !== 1'b1) begin errors++; $display("FAIL reset_sync got %0b%0b want 11", h_sync_out, v_sync_out); end
        checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %0b want 0", wr_drop); end
        rst = 1'b1;
        tick();
        checks++; if (wr_ready !== exp_ready) begin errors++; $display("FAIL release_wr_ready got %0b want %0b", wr_ready, exp_ready); end
        // Mid-frame reset with three pixels queued
        drive_video(1, 20, 30, 0, 1);
        for (int i = 0; i < 3; i++) begin
            drive_wr(1, 100 + i, 410, 16 + i);
            tick();
        end
        drive_wr(0, 0, 0, 0);
        checks++; if (int'(fifo_level) != mq.size()) begin errors++; $display("FAIL pre_reset_level got %0d want %0d", fifo_level, mq.size()); end
        #2 rst = 1'b0;
        #1;
        checks++; if (fifo_level !== '0) begin errors++; $display("FAIL midreset_level got %0d want 0", fifo_level); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL midreset_we got %0b want 0", mem_we); end
        checks++; if (h_sync_out !== 1'b1 || v_sync_out !== 1'b1) begin errors++; $display("FAIL midreset_sync got %0b%0b want 11", h_sync_out, v_sync_out); end
        checks++; if (pix_data !== '0) begin errors++; $display("FAIL midreset_pix got %0h want 0", pix_data); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready got %0b want 0", wr_ready); end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_video(0, 0, 0, 1, 1);
        tick();
    endtask

    task automatic test_latency();
        drive_wr(0, 0, 0, 0);
        drive_video(0, 0, 0, 1, 1);
        tick(); tick(); tick();
        drive_video(1, 5, 2, 0, 0);
        tick();
        checks++; if (mem_addr !== 19'd1285) begin errors++; $display("FAIL latency_addr got %0d want 1285", mem_addr); end
        drive_video(0, 0, 0, 1, 1);
        for (int i = 0; i < 2; i++) begin
            checks++; if (pix_data !== exp_pix() || blank_n_out !== hist[0].blank) begin
                errors++; $display("FAIL latency_early%0d got pix %0h blank %0b want %0h %0b", i, pix_data, blank_n_out, exp_pix(), hist[0].blank);
            end
            tick();
        end
        checks++; if (pix_data !== 8'd5) begin errors++; $display("FAIL latency_pix got %0h want 05", pix_data); end
        checks++; if (pix_data !== exp_pix()) begin errors++; $display("FAIL latency_model got %0h want %0h", pix_data, exp_pix()); end
        checks++; if (blank_n_out !== 1'b1 || h_sync_out !== 1'b0 || v_sync_out !== 1'b0) begin
            errors++; $display("FAIL latency_align got b%0b h%0b v%0b want 1 0 0", blank_n_out, h_sync_out, v_sync_out);
        end
        tick();
        checks++; if (blank_n_out !== 1'b0 || h_sync_out !== 1'b1 || pix_data !== '0) begin
            errors++; $display("FAIL latency_after got b%0b h%0b pix %0h want 0 1 0", blank_n_out, h_sync_out, pix_data);
        end
    endtask

    task automatic test_arbitration();
        int xs[4];
        int ys[4];
        xs = '{639, 0, 17, 320};
        ys = '{479, 400, 450, 479};
        for (int i = 0; i < 4; i++) begin
            drive_video(1, 100 + i, 7, 0, 1);
            drive_wr(1, xs[i], ys[i], $urandom_range(0, 255));
            tick();
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL arb_active_we%0d got %0b want 0", i, mem_we); end
        end
        drive_wr(1, 1, 401, 8'h3c);
        tick();
        drive_wr(0, 0, 0, 0);
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL arb_level got %0d want 4", fifo_level); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL arb_ready got %0b want 0", wr_ready); end
        checks++; if (mem_we !== 1'b0 || wr_drop !== 1'b0) begin errors++; $display("FAIL arb_full_we got we %0b drop %0b want 0 0", mem_we, wr_drop); end
        drive_video(0, 0, 0, 1, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (mem_we !== exp_we || mem_addr !== exp_addr) begin
                errors++; $display("FAIL arb_drain%0d got we %0b addr %0d want %0b %0d", i, mem_we, mem_addr, exp_we, exp_addr);
            end
            if (exp_we) begin
                checks++; if (mem_wdata !== exp_wdata) begin errors++; $display("FAIL arb_wdata%0d got %0h want %0h", i, mem_wdata, exp_wdata); end
            end
            if (i == 0) begin
                checks++; if (mem_addr !== 19'd307199) begin errors++; $display("FAIL arb_corner_addr got %0d want 307199", mem_addr); end
            end
        end
        checks++; if (fifo_level !== '0) begin errors++; $display("FAIL arb_empty got %0d want 0", fifo_level); end
    endtask

    task automatic test_boundary();
        for (int i = 0; i < 4; i++) begin
            drive_video(1, 50 + i, 60, 0, 1);
            drive_wr(1, 10 * i, 420 + i, 8'h80 + i);
            tick();
        end
        drive_wr(0, 0, 0, 0);
        drive_video(0, 0, 0, 1, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (mem_we !== 1'b1 || mem_addr !== exp_addr) begin
                errors++; $display("FAIL bnd_drain%0d got we %0b addr %0d want 1 %0d", i, mem_we, mem_addr, exp_addr);
            end
        end
        drive_video(1, 200, 300, 0, 1);
        tick();
        checks++; if (mem_we !== 1'b0 || mem_addr !== addr_of(200, 300)) begin
            errors++; $display("FAIL bnd_scan got we %0b addr %0d want 0 %0d", mem_we, mem_addr, addr_of(200, 300));
        end
        checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL bnd_level got %0d want 2", fifo_level); end
        for (int i = 0; i < 3; i++) begin
            drive_video(1, 201 + i, 300, 0, 1);
            tick();
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL bnd_active_we%0d got %0b want 0", i, mem_we); end
        end
        drive_video(0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (mem_we !== exp_we || mem_addr !== exp_addr) begin
                errors++; $display("FAIL bnd_next%0d got we %0b addr %0d want %0b %0d", i, mem_we, mem_addr, exp_we, exp_addr);
            end
        end
    endtask

    task automatic test_range();
        drive_video(1, 9, 9, 0, 1);
        drive_wr(1, 640, 410, 8'h55);
        tick();
        checks++; if (wr_drop !== 1'b1 || fifo_level !== '0) begin errors++; $display("FAIL range_x got drop %0b level %0d want 1 0", wr_drop, fifo_level); end
        drive_wr(0, 0, 0, 0);
        tick();
        checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL range_pulse got %0b want 0", wr_drop); end
        drive_wr(1, 5, 480, 8'h66);
        tick();
        checks++; if (wr_drop !== 1'b1 || fifo_level !== '0) begin errors++; $display("FAIL range_y got drop %0b level %0d want 1 0", wr_drop, fifo_level); end
        drive_wr(1, 639, 479, 8'h11); tick();
        checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL range_edge_ok got %0b want 0", wr_drop); end
        drive_wr(1, 7, 440, 8'h22); tick();
        checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL range_level2 got %0d want 2", fifo_level); end
        drive_video(0, 0, 0, 1, 1);
        drive_wr(1, 30, 430, 8'h33);
        tick();
        drive_wr(0, 0, 0, 0);
        checks++; if (fifo_level !== 3'd2 || mem_we !== 1'b1) begin errors++; $display("FAIL pushpop got level %0d we %0b want 2 1", fifo_level, mem_we); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (mem_we !== exp_we || mem_addr !== exp_addr || int'(fifo_level) != mq.size()) begin
                errors++; $display("FAIL pushpop_drain%0d got we %0b addr %0d lvl %0d want %0b %0d %0d", i, mem_we, mem_addr, fifo_level, exp_we, exp_addr, mq.size());
            end
        end
    endtask

    task automatic test_readback();
        drive_video(1, 0, 0, 0, 1);
        drive_wr(1, 3, 1, 8'ha5);
        tick();
        drive_wr(0, 0, 0, 0);
        drive_video(0, 0, 0, 1, 1);
        tick(); tick();
        drive_video(1, 3, 1, 0, 1);
        tick();
        drive_video(0, 0, 0, 1, 1);
        tick(); tick();
        checks++; if (pix_data !== 8'ha5) begin errors++; $display("FAIL readback got %0h want a5", pix_data); end
    endtask

    task automatic test_random();
        bit b = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) b = !b;
            drive_video(b, $urandom_range(0, 639), $urandom_range(0, 399), 1'($urandom), 1'($urandom));
            drive_wr(1'($urandom), $urandom_range(0, 650), $urandom_range(400, 485), $urandom_range(0, 255));
            tick();
            checks++; if (wr_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready@%0d got %0b want %0b", n, wr_ready, exp_ready); end
            checks++; if (int'(fifo_level) != mq.size()) begin errors++; $display("FAIL rnd_level@%0d got %0d want %0d", n, fifo_level, mq.size()); end
            checks++; if (wr_drop !== exp_drop) begin errors++; $display("FAIL rnd_drop@%0d got %0b want %0b", n, wr_drop, exp_drop); end
            checks++; if (mem_we !== exp_we) begin errors++; $display("FAIL rnd_we@%0d got %0b want %0b", n, mem_we, exp_we); end
            checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL rnd_addr@%0d got %0d want %0d", n, mem_addr, exp_addr); end
            if (exp_we) begin
                checks++; if (mem_wdata !== exp_wdata) begin errors++; $display("FAIL rnd_wdata@%0d got %0h want %0h", n, mem_wdata, exp_wdata); end
            end
            checks++; if (pix_data !== exp_pix()) begin errors++; $display("FAIL rnd_pix@%0d got %0h want %0h", n, pix_data, exp_pix()); end
            checks++; if (blank_n_out !== hist[0].blank) begin errors++; $display("FAIL rnd_blank@%0d got %0b want %0b", n, blank_n_out, hist[0].blank); end
            checks++; if (h_sync_out !== hist[0].hs || v_sync_out !== hist[0].vs) begin
                errors++; $display("FAIL rnd_sync@%0d got %0b%0b want %0b%0b", n, h_sync_out, v_sync_out, hist[0].hs, hist[0].vs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_arbitration();
        test_boundary();
        test_range();
        test_readback();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
